// File: rtl/lcd_pattern_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pattern_writer
// Description : Streams a full H_DISP x V_DISP RGB test frame into the SDRAM
//               controller write FIFO. Six selectable patterns, per-frame
//               scrolling, one-shot or continuous operation, FIFO
//               back-pressure, frame counting and abort on loss of sys_vaild.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_pattern_writer #(
    parameter int                H_DISP      = 1024,
    parameter int                V_DISP      = 768,
    parameter int                COLOR_W     = 8,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
    parameter int                LOAD_GAP    = 16,
    parameter int                GRAY_SHIFT  = 2,
    parameter int                CHECK_SHIFT = 5,
    parameter int                SCROLL_STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sys_vaild,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [2:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic                   wr_ready,
    output logic                   sys_load,
    output logic                   sys_we,
    output logic [3*COLOR_W-1:0]   sys_data,
    output logic [ADDR_W-1:0]      sys_addr_min,
    output logic [ADDR_W-1:0]      sys_addr_max,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt
);

    localparam int c_XW       = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int c_YW       = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int c_GW       = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
    localparam int c_STEP_MOD = SCROLL_STEP % H_DISP;
    localparam longint c_PIX  = longint'(H_DISP) * longint'(V_DISP);

    localparam logic [c_XW-1:0] c_X_LAST    = c_XW'(H_DISP - 1);
    localparam logic [c_YW-1:0] c_Y_LAST    = c_YW'(V_DISP - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
    localparam logic [c_XW:0]   c_H_WIDE    = (c_XW + 1)'(H_DISP);
    localparam logic [c_XW:0]   c_STEP_WIDE = (c_XW + 1)'(c_STEP_MOD);
    localparam logic [31:0]     c_CELL_MASK = (32'd1 << CHECK_SHIFT) - 32'd1;

    // The frame must be addressable within the address bus.
    if ((ADDR_W < 63) && (c_PIX > ((longint'(1) << ADDR_W) - 1))) begin : g_addr_range_check
        $error("lcd_pattern_writer: H_DISP*V_DISP does not fit in ADDR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_XW-1:0]      r_x;
    logic [c_YW-1:0]      r_y;
    logic [c_GW-1:0]      r_gap;
    logic [c_XW-1:0]      r_offset;
    logic [2:0]           r_mode;
    logic [3*COLOR_W-1:0] r_solid;
    logic [15:0]          r_frame_cnt;
    logic                 r_sys_load;
    logic                 r_sys_we;
    logic [3*COLOR_W-1:0] r_sys_data;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [3*COLOR_W-1:0] w_pix;
    logic [c_XW:0]        w_xs_sum;
    logic [c_XW:0]        w_xs;
    logic [c_XW:0]        w_off_sum;
    logic [c_XW-1:0]      w_off_next;

    // Colour-bar index from elaboration-time thresholds, returned as an RGB on/off mask.
    function automatic logic [2:0] f_bar_mask(input logic [c_XW:0] xv);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (32'(xv) >= 32'((i * H_DISP) / 8)) idx = idx + 3'd1;
        end
        case (idx)
            3'd0:    f_bar_mask = 3'b111;
            3'd1:    f_bar_mask = 3'b110;
            3'd2:    f_bar_mask = 3'b011;
            3'd3:    f_bar_mask = 3'b010;
            3'd4:    f_bar_mask = 3'b101;
            3'd5:    f_bar_mask = 3'b100;
            3'd6:    f_bar_mask = 3'b001;
            default: f_bar_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [3*COLOR_W-1:0] f_expand(input logic [2:0] m);
        f_expand = {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
    endfunction

    // Pattern generator for the current (x, y) plus next scroll offset arithmetic.
    always_comb begin
        w_xs_sum   = {1'b0, r_x} + {1'b0, r_offset};
        w_xs       = (w_xs_sum >= c_H_WIDE) ? (w_xs_sum - c_H_WIDE) : w_xs_sum;
        w_off_sum  = {1'b0, r_offset} + c_STEP_WIDE;
        w_off_next = (w_off_sum >= c_H_WIDE) ? c_XW'(w_off_sum - c_H_WIDE) : c_XW'(w_off_sum);
        w_pix      = '0;
        case (r_mode)
            3'd0: w_pix = r_solid;
            3'd1: w_pix = f_expand(f_bar_mask({1'b0, r_x}));
            3'd2: w_pix = {3{COLOR_W'(32'(r_x) >> GRAY_SHIFT)}};
            3'd3: w_pix = f_expand({3{((32'(r_x) >> CHECK_SHIFT) & 32'd1) ==
                                      ((32'(r_y) >> CHECK_SHIFT) & 32'd1)}});
            3'd4: w_pix = f_expand({3{((32'(r_x) & c_CELL_MASK) == 32'd0) ||
                                      ((32'(r_y) & c_CELL_MASK) == 32'd0) ||
                                      (r_x == c_X_LAST) || (r_y == c_Y_LAST)}});
            3'd5: w_pix = f_expand(f_bar_mask(w_xs));
            default: w_pix = '0;
        endcase
    end

    // Frame sequencer: IDLE -> LOAD -> GAP -> WRITE -> DONE with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_gap        <= '0;
            r_offset     <= '0;
            r_mode       <= '0;
            r_solid      <= '0;
            r_frame_cnt  <= '0;
            r_sys_load   <= 1'b0;
            r_sys_we     <= 1'b0;
            r_sys_data   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sys_load   <= 1'b0;
            r_sys_we     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sys_vaild && (start || continuous)) begin
                        r_state    <= S_LOAD;
                        r_sys_load <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!sys_vaild) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_mode  <= mode;
                        r_solid <= solid_rgb;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_gap   <= '0;
                        r_state <= (LOAD_GAP > 0) ? S_GAP : S_WRITE;
                    end
                end
                S_GAP: begin
                    if (!sys_vaild) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap == c_GAP_LAST) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!sys_vaild) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (wr_ready) begin
                        r_sys_we   <= 1'b1;
                        r_sys_data <= w_pix;
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            if (r_y == c_Y_LAST) r_state <= S_DONE;
                            else                 r_y     <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                    // Restart the scroll sequence whenever the frame counter wraps.
                    r_offset     <= (r_frame_cnt == 16'hFFFF) ? '0 : w_off_next;
                    if (continuous && sys_vaild) begin
                        r_state    <= S_LOAD;
                        r_sys_load <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sys_load     = r_sys_load;
    assign sys_we       = r_sys_we;
    assign sys_data     = r_sys_data;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign frame_cnt    = r_frame_cnt;
    assign sys_addr_min = ADDR_BASE;
    assign sys_addr_max = ADDR_BASE + ADDR_W'(c_PIX);

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcd_pattern_writer
// Description : Directed and randomized checks of lcd_pattern_writer against
//               an arithmetic pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_pattern_writer;

    localparam int H    = 16;
    localparam int V    = 4;
    localparam int NPIX = H * V;
    localparam int GAP  = 4;
    localparam int GS   = 2;
    localparam int CS   = 2;
    localparam int STEP = 1;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst_n, sys_vaild, start, continuous, wr_ready;
    logic [2:0]  mode;
    logic [23:0] solid_rgb;
    logic        sys_load, sys_we, busy, frame_done;
    logic [23:0] sys_data;
    logic [31:0] sys_addr_min, sys_addr_max;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int addr_bad = 0;
    int we_after_stall = 0;
    int exp_cnt = 0;
    logic busy_at_done;
    logic [23:0] beats[$];
    int we_cyc[$];
    int loads[$];
    int dones[$];

    always #5 clk = ~clk;

    lcd_pattern_writer #(
        .H_DISP(H), .V_DISP(V), .COLOR_W(8), .ADDR_W(32), .ADDR_BASE(32'd0),
        .LOAD_GAP(GAP), .GRAY_SHIFT(GS), .CHECK_SHIFT(CS), .SCROLL_STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild), .start(start),
        .continuous(continuous), .mode(mode), .solid_rgb(solid_rgb), .wr_ready(wr_ready),
        .sys_load(sys_load), .sys_we(sys_we), .sys_data(sys_data),
        .sys_addr_min(sys_addr_min), .sys_addr_max(sys_addr_max), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Reference pixel computed straight from the pattern definitions.
    function automatic logic [23:0] model_pix(input int m, input logic [23:0] s,
                                              input int x, input int y, input int off);
        int g;
        case (m)
            0: return s;
            1: return BARS[(x * 8) / H];
            2: begin
                g = (x >> GS) % 256;
                return {g[7:0], g[7:0], g[7:0]};
            end
            3: return ((((x >> CS) + (y >> CS)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            4: return (((x % (1 << CS)) == 0) || ((y % (1 << CS)) == 0) ||
                       (x == H - 1) || (y == V - 1)) ? 24'hFFFFFF : 24'h000000;
            5: return BARS[(((x + off) % H) * 8) / H];
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        beats.delete(); we_cyc.delete(); loads.delete(); dones.delete();
    endtask

    // Advance one clock and log what the DUT presents in the new cycle.
    task automatic tick();
        logic prev_ready;
        prev_ready = wr_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (sys_we === 1'b1) begin
            beats.push_back(sys_data);
            we_cyc.push_back(cyc);
            if (prev_ready !== 1'b1) we_after_stall++;
        end
        if (sys_load === 1'b1) loads.push_back(cyc);
        if (frame_done === 1'b1) begin
            dones.push_back(cyc);
            busy_at_done = busy;
        end
        if (sys_addr_min !== 32'd0 || sys_addr_max !== 32'd64) addr_bad++;
    endtask

    // rpol: 0 = ready always, 1 = toggle, 2 = random. chg_at: beat count at which mode/solid change.
    task automatic run_frame(input logic [2:0] m, input logic [23:0] s, input int rpol, input int chg_at);
        clear_logs();
        mode = m; solid_rgb = s; start = 1'b1; wr_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            tick();
            start = 1'b0;
            if (rpol == 1) wr_ready = ~wr_ready;
            else if (rpol == 2) wr_ready = ($urandom_range(0, 3) != 0);
            if (beats.size() == chg_at) begin
                mode = 3'd0; solid_rgb = 24'h123456;
            end
            if (dones.size() > 0) break;
        end
        wr_ready = 1'b1;
        chk("frame_timeout", dones.size(), 1);
    endtask

    task automatic frame_checks(input string tag, input int m, input logic [23:0] s, input int off, input int rpol);
        exp_cnt++;
        chk({tag, "_beats"}, beats.size(), NPIX);
        for (int i = 0; i < NPIX && i < beats.size(); i++)
            chk({tag, "_pix"}, beats[i], model_pix(m, s, i % H, i / H, off));
        chk({tag, "_loads"}, loads.size(), 1);
        if (loads.size() > 0 && we_cyc.size() > 0)
            chk({tag, "_gap"}, 32'(we_cyc[0] - loads[0] >= GAP + 2), 1);
        if (dones.size() > 0 && we_cyc.size() > 0)
            chk({tag, "_done_lat"}, dones[0], we_cyc[we_cyc.size() - 1] + 1);
        if (rpol == 0 && we_cyc.size() > 0)
            chk({tag, "_consec"}, we_cyc[we_cyc.size() - 1] - we_cyc[0], NPIX - 1);
        chk({tag, "_busy_done"}, busy_at_done, 0);
        chk({tag, "_cnt"}, frame_cnt, exp_cnt);
        chk({tag, "_stall"}, we_after_stall, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        logic [2:0]  rm;
        logic [23:0] rs;
        int          off;
        rst_n = 1'b0; sys_vaild = 1'b1; start = 1'b0; continuous = 1'b0;
        wr_ready = 1'b1; mode = 3'd0; solid_rgb = 24'h0;
        do_reset();
        chk("rst_load", sys_load, 0);
        chk("rst_we", sys_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_data", sys_data, 0);
        chk("rst_cnt", frame_cnt, 0);

        // Colour bars, always ready.
        run_frame(3'd1, 24'h0, 0, -1);
        frame_checks("bars", 1, 24'h0, 0, 0);
        chk("bars_x2", beats[2], 24'hFFFF00);
        chk("bars_x10", beats[10], 24'hFF0000);

        // Colour bars with toggling back-pressure.
        run_frame(3'd1, 24'h0, 1, -1);
        frame_checks("toggle", 1, 24'h0, 0, 1);

        // Continuous scrolling, three frames.
        do_reset();
        clear_logs();
        mode = 3'd5; continuous = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (dones.size() >= 2) continuous = 1'b0;
            if (dones.size() >= 3) break;
        end
        chk("scroll_frames", dones.size(), 3);
        chk("scroll_beats", beats.size(), 3 * NPIX);
        chk("scroll_loads", loads.size(), 3);
        for (int f = 0; f < 3 && beats.size() >= 3 * NPIX; f++) begin
            for (int i = 0; i < NPIX; i++)
                chk("scroll_pix", beats[f * NPIX + i], model_pix(5, 24'h0, i % H, i / H, (f * STEP) % H));
            if (loads.size() > f) chk("scroll_load_order", 32'(loads[f] < we_cyc[f * NPIX]), 1);
        end
        if (beats.size() >= 3 * NPIX) begin
            chk("scroll_f1x0", beats[NPIX], 24'hFFFFFF);
            chk("scroll_f2x0", beats[2 * NPIX], 24'hFFFF00);
        end
        chk("scroll_cnt", frame_cnt, 3);
        exp_cnt = 3;

        // Checkerboard, black modes and a mid-frame mode change.
        run_frame(3'd3, 24'h0, 0, -1);
        frame_checks("checker", 3, 24'h0, 0, 0);
        chk("chk_0_0", beats[0], 24'hFFFFFF);
        chk("chk_4_0", beats[4], 24'h000000);
        chk("chk_8_0", beats[8], 24'hFFFFFF);
        chk("chk_4_1", beats[H + 4], 24'h000000);
        run_frame(3'd6, 24'hABCDEF, 0, -1);
        frame_checks("black", 6, 24'hABCDEF, 0, 0);
        run_frame(3'd3, 24'h0, 0, 10);
        frame_checks("midchange", 3, 24'h0, 0, 0);

        // Abort after the 20th write.
        clear_logs();
        mode = 3'd1; start = 1'b1;
        for (int n = 0; n < 500; n++) begin
            tick();
            start = 1'b0;
            if (beats.size() == 20) begin
                sys_vaild = 1'b0;
                break;
            end
        end
        repeat (10) tick();
        chk("abort_beats", beats.size(), 20);
        chk("abort_done", dones.size(), 0);
        chk("abort_cnt", frame_cnt, exp_cnt);
        chk("abort_busy", busy, 0);
        sys_vaild = 1'b1;
        run_frame(3'd1, 24'h0, 0, -1);
        frame_checks("post_abort", 1, 24'h0, 0, 0);

        // Reset in the middle of a frame.
        clear_logs();
        mode = 3'd2; start = 1'b1;
        for (int n = 0; n < 500; n++) begin
            tick();
            start = 1'b0;
            if (beats.size() == 10) break;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("mrst_we", sys_we, 0);
        chk("mrst_load", sys_load, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_data", sys_data, 0);
        repeat (3) tick();
        chk("mrst_idle", busy, 0);

        // Randomized patterns, colours and back-pressure.
        for (int k = 0; k < 8; k++) begin
            rm  = 3'($urandom_range(0, 7));
            rs  = 24'($urandom);
            off = (exp_cnt * STEP) % H;
            run_frame(rm, rs, 2, -1);
            frame_checks("rand", int'(rm), rs, off, 2);
        end

        chk("addr_const", addr_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
